shift_register_fifo: RTL



---
 rtl/shift_register_pkg.sv | 9 +
 rtl/shift_register_addressable.sv | 28 ++
 rtl/shift_register_fifo.sv | 94 +++++++++
 3 files changed

// File: rtl/shift_register_pkg.sv
// Shared helpers for the delay-line family: sizing of occupancy counters.
package shift_register_pkg;

    // Occupancy spans 0..DEPTH+1 (SRL entries plus one output register).
    function automatic int count_width(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/shift_register_addressable.sv
// Addressable shift register: shifts in on we, reads any tap combinationally.
// Kept free of reset so the storage maps onto SRL primitives.
module shift_register_addressable #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [DATA_WIDTH-1:0]    di,
    input  logic [$clog2(DEPTH)-1:0] addr,
    output logic [DATA_WIDTH-1:0]    q
);

    logic [DATA_WIDTH-1:0] sr [DEPTH];

    // NOTE: no reset on the storage array; a reset term would block SRL inference.
    always_ff @(posedge clk) begin
        if (we) begin
            sr[0] <= di;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[addr];

endmodule

// File: rtl/shift_register_fifo.sv
// Elastic FIFO on SRL storage with a registered first-word-fall-through output.
// Holds DEPTH SRL entries plus one output register; an empty queue bypasses the SRL.
module shift_register_fifo
    import shift_register_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(DEPTH + 1);
    localparam int CW = count_width(DEPTH);
    localparam logic [SW-1:0] SRL_FULL = SW'(DEPTH);

    generate
        if (DEPTH < 2 || DATA_WIDTH < 1) begin : g_bad_params
            $error("shift_register_fifo: DEPTH must be >= 2 and DATA_WIDTH >= 1");
        end
    endgenerate

    logic [SW-1:0]         srl_count;
    logic [SW-1:0]         srl_count_next;
    logic [AW-1:0]         head_addr;
    logic [DATA_WIDTH-1:0] head;
    logic                  push;
    logic                  out_free;
    logic                  pop_srl;
    logic                  bypass;
    logic                  srl_we;
    logic                  m_valid_next;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        push      = s_valid & s_ready;
        out_free  = !m_valid | m_ready;
        pop_srl   = out_free & (srl_count != '0);
        bypass    = out_free & (srl_count == '0) & push;
        srl_we    = push & !bypass;
        head_addr = (srl_count == '0) ? '0 : AW'(srl_count - 1'b1);

        srl_count_next = srl_count;
        if (srl_we && !pop_srl) begin
            srl_count_next = srl_count + 1'b1;
        end else if (pop_srl && !srl_we) begin
            srl_count_next = srl_count - 1'b1;
        end

        m_valid_next = out_free ? (pop_srl | bypass) : m_valid;
    end

    // A simultaneous shift and read is safe: the next head lands at srl_count-1.
    shift_register_addressable #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_srl (
        .clk (clk),
        .we  (srl_we),
        .di  (s_data),
        .addr(head_addr),
        .q   (head)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            srl_count <= '0;
            s_ready   <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            count     <= '0;
        end else begin
            srl_count <= srl_count_next;
            s_ready   <= (srl_count_next != SRL_FULL);
            m_valid   <= m_valid_next;
            count     <= CW'(srl_count_next) + CW'(m_valid_next);
            if (pop_srl) begin
                m_data <= head;
            end else if (bypass) begin
                m_data <= s_data;
            end
        end
    end

endmodule
